// File: rtl/k8088_bus_arbiter.sv
// Single-port RAM arbiter for the k8088 CPU, video fetch and DMA.
// Fixed priority video > DMA > CPU, with a starvation guard that forces a CPU slot.
module k8088_bus_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [19:0] cpu_address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   output logic        cpu_ce,
   output logic [7:0]  cpu_in,
   input  logic        vid_req,
   input  logic [19:0] vid_address,
   output logic        vid_ack,
   output logic        vid_valid,
   output logic [7:0]  vid_data,
   input  logic        dma_req,
   input  logic [19:0] dma_address,
   input  logic        dma_we,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic        dma_valid,
   output logic [7:0]  dma_rdata,
   output logic [19:0] mem_address,
   output logic [7:0]  mem_out,
   output logic        mem_we,
   input  logic [7:0]  mem_in,
   output logic [1:0]  owner
);

   localparam int unsigned SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

   typedef enum logic {StAddr, StData} cpu_state_e;

   cpu_state_e    state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          vid_valid_q, dma_valid_q;
   logic          cpu_req, guard;
   logic          cpu_grant, vid_grant, dma_grant;

   // Grant decision and next-state logic
   always_comb begin
      cpu_grant = 1'b0;
      vid_grant = 1'b0;
      dma_grant = 1'b0;
      starve_d  = starve_q;
      cpu_req   = (state_q == StAddr);
      guard     = (MAX_WAIT != 0) && (starve_q == STARVE_MAX) && cpu_req;

      if (!reset) begin
         if (guard) begin
            cpu_grant = 1'b1;
         end else if (vid_req) begin
            vid_grant = 1'b1;
         end else if (dma_req) begin
            dma_grant = 1'b1;
         end else if (cpu_req) begin
            cpu_grant = 1'b1;
         end
      end

      state_d = (cpu_req && cpu_grant) ? StData : StAddr;

      if (cpu_grant) begin
         starve_d = '0;
      end else if (cpu_req && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + SW'(1);
      end
   end

   // Bus mux; an idle bus parks on the CPU address with no write
   always_comb begin
      mem_address = cpu_address;
      mem_out     = 8'h00;
      mem_we      = 1'b0;
      owner       = 2'd0;
      if (cpu_grant) begin
         mem_out = cpu_out;
         mem_we  = cpu_we;
         owner   = 2'd1;
      end else if (vid_grant) begin
         mem_address = vid_address;
         owner       = 2'd2;
      end else if (dma_grant) begin
         mem_address = dma_address;
         mem_out     = dma_wdata;
         mem_we      = dma_we;
         owner       = 2'd3;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StAddr;
         starve_q    <= '0;
         vid_valid_q <= 1'b0;
         dma_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         vid_valid_q <= vid_grant;
         dma_valid_q <= dma_grant & ~dma_we;
      end
   end

   assign cpu_ce    = (state_q == StData) && !reset;
   assign cpu_in    = mem_in;
   assign vid_ack   = vid_grant;
   assign vid_valid = vid_valid_q;
   assign vid_data  = mem_in;
   assign dma_ack   = dma_grant;
   assign dma_valid = dma_valid_q;
   assign dma_rdata = mem_in;

endmodule
